// File: rtl/vga_sync_gen_if.sv
// Sync/position bundle from the VGA timing master to every draw module.
// The master drives all signals; draw modules only observe them.
interface vga_sync_gen_if;
    logic       hSync;
    logic       vSync;
    logic [9:0] display_x_pos;
    logic [9:0] display_y_pos;
    logic       active;
    logic       line_start;
    logic       frame_start;

    modport master (
        output hSync, vSync, display_x_pos, display_y_pos, active, line_start, frame_start
    );

    modport slave (
        input  hSync, vSync, display_x_pos, display_y_pos, active, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing master: free-running pixel/line counters with registered sync, active and
// line/frame markers, all derived from the next count so they change on the same edge.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           i_CLK,
    input  logic           i_RST_N,
    input  logic           i_pix_en,
    vga_sync_gen_if.master vga
);

    // Totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, y_q;
    logic [9:0] x_nxt, y_nxt;
    logic       x_wrap;
    logic       hsync_q, vsync_q, active_q, line_start_q, frame_start_q;
    logic       hsync_nxt, vsync_nxt, active_nxt;

    always_comb begin
        x_wrap = (x_q == H_LAST);
        x_nxt  = x_wrap ? 10'd0 : x_q + 10'd1;
        y_nxt  = y_q;
        if (x_wrap) begin
            y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    always_comb begin
        hsync_nxt  = ((x_nxt >= H_SYNC_START) && (x_nxt < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_nxt  = ((y_nxt >= V_SYNC_START) && (y_nxt < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        active_nxt = (x_nxt < H_ACT_END) && (y_nxt < V_ACT_END);
    end

    // Without a pixel enable everything holds except the markers, which are one-enable pulses.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (i_pix_en) begin
            x_q           <= x_nxt;
            y_q           <= y_nxt;
            hsync_q       <= hsync_nxt;
            vsync_q       <= vsync_nxt;
            active_q      <= active_nxt;
            line_start_q  <= (x_nxt == 10'd0);
            frame_start_q <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vga.hSync         = hsync_q;
    assign vga.vSync         = vsync_q;
    assign vga.display_x_pos = x_q;
    assign vga.display_y_pos = y_q;
    assign vga.active        = active_q;
    assign vga.line_start    = line_start_q;
    assign vga.frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance plus a tiny-timing instance
// (16x8 total) so frame wrap and vertical sync can be exercised in a short run.
module tb_vga_sync_gen;

    logic i_CLK = 1'b0;
    logic i_RST_N = 1'b0;
    logic i_pix_en = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 i_CLK = ~i_CLK;

    vga_sync_gen_if vga ();
    vga_sync_gen_if vga_s ();

    vga_sync_gen dut (
        .i_CLK    (i_CLK),
        .i_RST_N  (i_RST_N),
        .i_pix_en (i_pix_en),
        .vga      (vga.master)
    );

    // Small timing: H 8+2+3+3=16 (hsync x=10..12), V 4+1+2+1=8 (vsync y=5..6).
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_s (
        .i_CLK    (i_CLK),
        .i_RST_N  (i_RST_N),
        .i_pix_en (i_pix_en),
        .vga      (vga_s.master)
    );

    function automatic logic exp_hs(input int x);
        return !((x >= 656) && (x < 752));
    endfunction

    task automatic do_reset();
        i_RST_N  = 1'b0;
        i_pix_en = 1'b1;
        repeat (2) @(posedge i_CLK);
        #1;
        i_RST_N = 1'b1;
    endtask

    task automatic test_reset();
        i_RST_N  = 1'b0;
        i_pix_en = 1'b1;
        repeat (3) @(posedge i_CLK);
        #1;
        checks++; if (vga.display_x_pos !== 10'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", vga.display_x_pos); end
        checks++; if (vga.display_y_pos !== 10'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", vga.display_y_pos); end
        checks++; if (vga.hSync !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b exp 1", vga.hSync); end
        checks++; if (vga.vSync !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b exp 1", vga.vSync); end
        checks++; if (vga.active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", vga.active); end
        checks++; if (vga.line_start !== 1'b0) begin errors++; $display("FAIL rst_line_start got %b exp 0", vga.line_start); end
        checks++; if (vga.frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b exp 0", vga.frame_start); end
        i_RST_N = 1'b1;
        @(posedge i_CLK); #1;
        checks++; if (vga.display_x_pos !== 10'd1) begin errors++; $display("FAIL first_edge_x got %0d exp 1", vga.display_x_pos); end
        checks++; if (vga.active !== 1'b1) begin errors++; $display("FAIL first_edge_active got %b exp 1", vga.active); end
        checks++; if (vga.line_start !== 1'b0) begin errors++; $display("FAIL first_edge_line_start got %b exp 0", vga.line_start); end
    endtask

    task automatic test_hsync_active();
        int hs_low = 0, act = 0, ls = 0, fs = 0, bad = 0;
        int ex = 0, ey = 0;
        do_reset();
        // Observed state right after release is (0,0); walk two full lines from there.
        for (int i = 0; i < 1600; i++) begin
            @(posedge i_CLK); #1;
            if (ex == 799) begin ex = 0; ey++; end else ex++;
            if (vga.hSync === 1'b0) hs_low++;
            if (vga.active === 1'b1) act++;
            if (vga.line_start === 1'b1) ls++;
            if (vga.frame_start === 1'b1) fs++;
            if (vga.display_x_pos !== 10'(ex) || vga.display_y_pos !== 10'(ey) ||
                vga.hSync !== exp_hs(ex)) bad++;
        end
        checks++; if (hs_low != 192) begin errors++; $display("FAIL hsync_low_cycles got %0d exp 192", hs_low); end
        checks++; if (act != 1280) begin errors++; $display("FAIL active_cycles got %0d exp 1280", act); end
        checks++; if (ls != 2) begin errors++; $display("FAIL line_start_count got %0d exp 2", ls); end
        checks++; if (fs != 0) begin errors++; $display("FAIL frame_start_count got %0d exp 0", fs); end
        checks++; if (bad != 0) begin errors++; $display("FAIL hsync_position_track got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_line_wrap();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if (vga.display_x_pos == 10'd799 && vga.display_y_pos == 10'd10) begin found = 1; break; end
            @(posedge i_CLK); #1;
        end
        checks++; if (!found) begin errors++; $display("FAIL reach_799_10 got timeout exp reached"); end
        @(posedge i_CLK); #1;
        checks++; if (vga.display_x_pos !== 10'd0) begin errors++; $display("FAIL wrap_x got %0d exp 0", vga.display_x_pos); end
        checks++; if (vga.display_y_pos !== 10'd11) begin errors++; $display("FAIL wrap_y got %0d exp 11", vga.display_y_pos); end
        checks++; if (vga.line_start !== 1'b1) begin errors++; $display("FAIL wrap_line_start got %b exp 1", vga.line_start); end
        checks++; if (vga.frame_start !== 1'b0) begin errors++; $display("FAIL wrap_frame_start got %b exp 0", vga.frame_start); end
        @(posedge i_CLK); #1;
        checks++; if (vga.line_start !== 1'b0) begin errors++; $display("FAIL line_start_width got %b exp 0", vga.line_start); end
        checks++; if (vga.display_x_pos !== 10'd1) begin errors++; $display("FAIL after_wrap_x got %0d exp 1", vga.display_x_pos); end
    endtask

    task automatic test_frame_wrap();
        bit found = 0;
        int early_fs = 0, n = 0, vs_low = 0, hs_low = 0, bad = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (vga_s.display_x_pos == 10'd15 && vga_s.display_y_pos == 10'd7) begin found = 1; break; end
            @(posedge i_CLK); #1;
            if (vga_s.frame_start === 1'b1) early_fs++;
        end
        checks++; if (!found) begin errors++; $display("FAIL reach_15_7 got timeout exp reached"); end
        checks++; if (early_fs != 0) begin errors++; $display("FAIL first_frame_no_fs got %0d exp 0", early_fs); end
        @(posedge i_CLK); #1;
        checks++; if (vga_s.display_x_pos !== 10'd0 || vga_s.display_y_pos !== 10'd0) begin
            errors++; $display("FAIL frame_wrap_pos got (%0d,%0d) exp (0,0)", vga_s.display_x_pos, vga_s.display_y_pos); end
        checks++; if (vga_s.frame_start !== 1'b1) begin errors++; $display("FAIL frame_start got %b exp 1", vga_s.frame_start); end
        checks++; if (vga_s.line_start !== 1'b1) begin errors++; $display("FAIL frame_line_start got %b exp 1", vga_s.line_start); end
        for (int i = 0; i < 300; i++) begin
            @(posedge i_CLK); #1;
            n++;
            if (vga_s.vSync === 1'b0) vs_low++;
            if (vga_s.hSync === 1'b0) hs_low++;
            if (vga_s.vSync !== !(vga_s.display_y_pos == 10'd5 || vga_s.display_y_pos == 10'd6)) bad++;
            if (vga_s.frame_start === 1'b1) break;
        end
        checks++; if (n != 128) begin errors++; $display("FAIL frame_period got %0d exp 128", n); end
        checks++; if (vs_low != 32) begin errors++; $display("FAIL vsync_low_cycles got %0d exp 32", vs_low); end
        checks++; if (hs_low != 24) begin errors++; $display("FAIL small_hsync_low got %0d exp 24", hs_low); end
        checks++; if (bad != 0) begin errors++; $display("FAIL vsync_rows got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_pix_en_toggle();
        int ex = 0, ey = 0, bad = 0, first = -1, second = -1;
        logic els;
        do_reset();
        for (int i = 0; i < 3300; i++) begin
            i_pix_en = (i % 2 == 0);
            @(posedge i_CLK); #1;
            els = 1'b0;
            if (i_pix_en) begin
                if (ex == 799) begin ex = 0; ey++; end else ex++;
                els = (ex == 0);
            end
            if (vga.display_x_pos !== 10'(ex) || vga.display_y_pos !== 10'(ey) ||
                vga.line_start !== els || vga.hSync !== exp_hs(ex)) bad++;
            if (vga.line_start === 1'b1) begin
                if (first < 0) first = i; else if (second < 0) second = i;
            end
        end
        i_pix_en = 1'b1;
        checks++; if (bad != 0) begin errors++; $display("FAIL toggle_track got %0d bad cycles exp 0", bad); end
        checks++; if (second - first != 1600) begin errors++; $display("FAIL toggle_line_period got %0d exp 1600", second - first); end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            if (vga.display_x_pos == 10'd700 && vga.display_y_pos == 10'd3) begin found = 1; break; end
            @(posedge i_CLK); #1;
        end
        checks++; if (!found) begin errors++; $display("FAIL reach_700_3 got timeout exp reached"); end
        checks++; if (vga.hSync !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync got %b exp 0", vga.hSync); end
        #2 i_RST_N = 1'b0;
        #1;
        checks++; if (vga.display_x_pos !== 10'd0 || vga.display_y_pos !== 10'd0) begin
            errors++; $display("FAIL async_rst_pos got (%0d,%0d) exp (0,0)", vga.display_x_pos, vga.display_y_pos); end
        checks++; if (vga.hSync !== 1'b1) begin errors++; $display("FAIL async_rst_hsync got %b exp 1", vga.hSync); end
        checks++; if (vga.active !== 1'b0) begin errors++; $display("FAIL async_rst_active got %b exp 0", vga.active); end
        #1 i_RST_N = 1'b1;
        @(posedge i_CLK); #1;
        checks++; if (vga.display_x_pos !== 10'd1 || vga.display_y_pos !== 10'd0) begin
            errors++; $display("FAIL restart_pos got (%0d,%0d) exp (1,0)", vga.display_x_pos, vga.display_y_pos); end
    endtask

    initial begin
        test_reset();
        test_hsync_active();
        test_line_wrap();
        test_frame_wrap();
        test_pix_en_toggle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
